// File: rtl/top_share_pkg.sv
// ============================================================================
// Module : top_share_pkg
// Brief  : Shared types and constants for the time-shared arithmetic core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package top_share_pkg;

    localparam int CNT_W   = 8;
    localparam int OPCNT_W = 16;
    localparam logic [OPCNT_W-1:0] OPCNT_MAX = {OPCNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; on a tie the side not granted last wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/top.sv
// ============================================================================
// Module : top
// Brief  : Combinational arithmetic core (product of IN1 and IN2) shared by
//          the scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module top #(
    parameter int WIDTH1   = 8,
    parameter int WIDTH2   = 8,
    parameter int OUTWIDTH = 16
) (
    input  logic [WIDTH1-1:0]   IN1,
    input  logic [WIDTH2-1:0]   IN2,
    output logic [OUTWIDTH-1:0] P
);

    logic [WIDTH1+WIDTH2-1:0] w_prod;

    assign w_prod = {{WIDTH2{1'b0}}, IN1} * {{WIDTH1{1'b0}}, IN2};
    assign P      = OUTWIDTH'(w_prod);

endmodule

`default_nettype wire

// File: rtl/top_share_sched.sv
// ============================================================================
// Module : top_share_sched
// Brief  : Round-robin time-sharing of one combinational core between two
//          requesters, with fixed settle time and id-tagged results.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module top_share_sched
    import top_share_pkg::*;
#(
    parameter int WIDTH1        = 8,
    parameter int WIDTH2        = 8,
    parameter int OUTWIDTH      = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH1-1:0]   req0_a,
    input  logic [WIDTH2-1:0]   req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH1-1:0]   req1_a,
    input  logic [WIDTH2-1:0]   req1_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OUTWIDTH-1:0] res_p,
    output logic                res_id,
    output logic                busy,
    output logic [15:0]         op_count
);

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_last_grant;
    logic [WIDTH1-1:0]     r_in1;
    logic [WIDTH2-1:0]     r_in2;
    logic [OUTWIDTH-1:0]   r_res_p;
    logic                  r_res_valid;
    logic                  r_res_id;
    logic [OPCNT_W-1:0]    r_op_count;
    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_accept;
    logic [OUTWIDTH-1:0]   w_p;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    top #(
        .WIDTH1   (WIDTH1),
        .WIDTH2   (WIDTH2),
        .OUTWIDTH (OUTWIDTH)
    ) u_core (
        .IN1 (r_in1),
        .IN2 (r_in2),
        .P   (w_p)
    );

    assign w_idle     = (r_state == IDLE);
    assign req0_ready = w_idle & w_grant[0];
    assign req1_ready = w_idle & w_grant[1];
    assign w_accept   = w_idle & (|w_grant);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)       w_state_nxt = SETTLE;
            SETTLE:  if (r_cnt == '0)    w_state_nxt = DONE;
            DONE:    if (res_ready)      w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_in1        <= '0;
            r_in2        <= '0;
            r_res_p      <= '0;
            r_res_valid  <= 1'b0;
            r_res_id     <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    // Operands are only written on accept so the core inputs stay quiet while idle.
                    if (w_accept) begin
                        r_in1        <= w_grant[1] ? req1_a : req0_a;
                        r_in2        <= w_grant[1] ? req1_b : req0_b;
                        r_res_id     <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_cnt        <= c_CNT_LOAD;
                    end
                end
                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_res_p     <= w_p;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_op_count != OPCNT_MAX) begin
                            r_op_count <= r_op_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_p     = r_res_p;
    assign res_id    = r_res_id;
    assign busy      = ~w_idle;
    assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_top_share_sched.sv
// ============================================================================
// Module : tb_top_share_sched
// Brief  : Directed self-checking bench for top_share_sched (default, 1- and
//          5-cycle settle builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_top_share_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, res_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, res_valid, res_id, busy;
    logic [15:0] res_p, op_count;

    logic        v1, v5;
    logic [7:0]  sa, sb;
    logic        d1_r0_ready, d1_r1_ready, d1_res_valid, d1_res_id, d1_busy;
    logic [15:0] d1_res_p, d1_op_count;
    logic        d5_r0_ready, d5_r1_ready, d5_res_valid, d5_res_id, d5_busy;
    logic [15:0] d5_res_p, d5_op_count;

    int n_total = 0;
    int n_fail  = 0;

    top_share_sched u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id),
        .busy(busy), .op_count(op_count)
    );

    top_share_sched #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v1), .req0_ready(d1_r0_ready), .req0_a(sa), .req0_b(sb),
        .req1_valid(1'b0), .req1_ready(d1_r1_ready), .req1_a(8'd0), .req1_b(8'd0),
        .res_valid(d1_res_valid), .res_ready(1'b1), .res_p(d1_res_p), .res_id(d1_res_id),
        .busy(d1_busy), .op_count(d1_op_count)
    );

    top_share_sched #(.SETTLE_CYCLES(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .req0_valid(v5), .req0_ready(d5_r0_ready), .req0_a(sa), .req0_b(sb),
        .req1_valid(1'b0), .req1_ready(d5_r1_ready), .req1_a(8'd0), .req1_b(8'd0),
        .res_valid(d5_res_valid), .res_ready(1'b1), .res_p(d5_res_p), .res_id(d5_res_id),
        .busy(d5_busy), .op_count(d5_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : stim
        int lat1, lat5;
        logic [15:0] hold_p;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        v1 = 0; v5 = 0; sa = 0; sb = 0;
        do_reset();

        // Reset state
        check("rst_res_valid", res_valid, 0);
        check("rst_res_p", res_p, 0);
        check("rst_res_id", res_id, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);

        // Single request from requester 0
        req0_valid = 1; req0_a = 8'd3; req0_b = 8'd5; res_ready = 1;
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        step();
        req0_valid = 0;
        check("t1_busy", busy, 1);
        check("t1_valid_e1", res_valid, 0);
        step();
        check("t1_valid_e2m", res_valid, 0);
        step();
        check("t1_valid_e2", res_valid, 1);
        check("t1_res_p", res_p, 16'd15);
        check("t1_res_id", res_id, 0);
        step();
        check("t1_valid_after", res_valid, 0);
        check("t1_op_count", op_count, 1);
        check("t1_busy_after", busy, 0);

        // Both requesters continuously valid: alternating ids, requester 0 first
        do_reset();
        req0_valid = 1; req0_a = 8'd7;  req0_b = 8'd9;
        req1_valid = 1; req1_a = 8'd10; req1_b = 8'd11;
        res_ready = 1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 10 && !res_valid; i++) begin
                check("t2_ready_onehot", req0_ready & req1_ready, 0);
                step();
            end
            check("t2_res_valid", res_valid, 1);
            check("t2_res_id", res_id, k % 2);
            check("t2_res_p", res_p, (k % 2) ? 16'd110 : 16'd63);
            if (k == 3) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            step();
        end
        check("t2_op_count", op_count, 4);

        // Consumer stalls for 10 cycles in DONE
        res_ready = 0;
        req0_valid = 1; req0_a = 8'd200; req0_b = 8'd100;
        #1;
        check("t3_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        req1_valid = 1;
        for (int i = 0; i < 10 && !res_valid; i++) step();
        check("t3_res_valid", res_valid, 1);
        hold_p = res_p;
        check("t3_res_p", res_p, 16'd20000);
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_p", res_p, 16'd20000);
            check("t3_hold_id", res_id, 0);
            check("t3_hold_ready", {req1_ready, req0_ready}, 0);
            check("t3_hold_busy", busy, 1);
        end
        check("t3_hold_p_stable", res_p, hold_p);
        res_ready = 1;
        step();
        check("t3_released", res_valid, 0);
        check("t3_op_count", op_count, 5);
        check("t3_req1_ready_idle", req1_ready, 1);
        req1_valid = 0;
        step();
        check("t3_no_accept", busy, 0);

        // Reset asserted during SETTLE
        do_reset();
        req0_valid = 1; req0_a = 8'd1; req0_b = 8'd2;
        step();
        req0_valid = 0;
        check("t4_busy_settle", busy, 1);
        rst = 1;
        step();
        check("t4_rst_busy", busy, 0);
        check("t4_rst_valid", res_valid, 0);
        check("t4_rst_p", res_p, 0);
        check("t4_rst_id", res_id, 0);
        check("t4_rst_op_count", op_count, 0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_no_result", res_valid, 0);
        end
        check("t4_op_count_after", op_count, 0);

        // Settle latency for 1- and 5-cycle builds
        sa = 8'd6; sb = 8'd7;
        v1 = 1; v5 = 1;
        #1;
        check("t5_ready1", d1_r0_ready, 1);
        check("t5_ready5", d5_r0_ready, 1);
        step();
        v1 = 0; v5 = 0;
        lat1 = 0; lat5 = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (d1_res_valid && lat1 == 0) lat1 = k;
            if (d5_res_valid && lat5 == 0) lat5 = k;
            if (k == 1) check("t5_p1", d1_res_p, 16'd42);
            if (k == 5) check("t5_p5", d5_res_p, 16'd42);
        end
        check("t5_lat1", lat1, 1);
        check("t5_lat5", lat5, 5);
        check("t5_cnt1", d1_op_count, 1);
        check("t5_cnt5", d5_op_count, 1);

        // Saturation of the completed-operation counter
        force u_dut1.r_op_count = 16'hFFFD;
        step();
        release u_dut1.r_op_count;
        step();
        check("t6_preload", d1_op_count, 16'hFFFD);
        for (int k = 0; k < 3; k++) begin
            v1 = 1;
            step();
            v1 = 0;
            step();
            check("t6_valid", d1_res_valid, 1);
            step();
            check("t6_op_count", d1_op_count, (k == 0) ? 16'hFFFE : 16'hFFFF);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

`default_nettype wire
